spi_master_arbiter: RTL and testbench

SPI_MASTER_ARBITER -- requirements
Module: spi_master_arbiter

---
 rtl/spi_master_arbiter.sv | 147 ++++++++++++++
 tb/tb_spi_master_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_arbiter.sv
`default_nettype none
// spi_master_arbiter: round-robin arbitration of two requesters onto one SPI master,
// with drain-before-handover and an optional per-grant hold timeout.
module spi_master_arbiter #(
  parameter int DataWidth    = 8,
  parameter int TimeoutWidth = 16
) (
  input  logic                    Clk_i,
  input  logic                    Reset_n_i,
  input  logic                    Req0_i,
  input  logic                    Req1_i,
  output logic                    Grant0_o,
  output logic                    Grant1_o,
  input  logic                    Req0_SPI_Write_i,
  input  logic                    Req0_SPI_ReadNext_i,
  input  logic [DataWidth-1:0]    Req0_SPI_Data_i,
  input  logic                    Req0_CS_n_i,
  input  logic                    Req1_SPI_Write_i,
  input  logic                    Req1_SPI_ReadNext_i,
  input  logic [DataWidth-1:0]    Req1_SPI_Data_i,
  input  logic                    Req1_CS_n_i,
  output logic                    Req0_SPI_FIFOFull_o,
  output logic                    Req0_SPI_FIFOEmpty_o,
  output logic                    Req0_SPI_Transmission_o,
  output logic                    Req1_SPI_FIFOFull_o,
  output logic                    Req1_SPI_FIFOEmpty_o,
  output logic                    Req1_SPI_Transmission_o,
  output logic [DataWidth-1:0]    SPI_Data_o,
  output logic                    SPI_Write_o,
  output logic                    SPI_ReadNext_o,
  input  logic                    SPI_FIFOFull_i,
  input  logic                    SPI_FIFOEmpty_i,
  input  logic                    SPI_Transmission_i,
  output logic                    CS0_n_o,
  output logic                    CS1_n_o,
  input  logic [TimeoutWidth-1:0] Timeout_i,
  output logic                    TimeoutIrq_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  state_t                  state;
  logic                    last_served;
  logic                    blocked0;
  logic                    blocked1;
  logic                    grant0;
  logic                    grant1;
  logic                    timeout_irq;
  logic [TimeoutWidth-1:0] hold_cnt;

  logic elig0;
  logic elig1;
  logic owner_req;

  assign elig0     = Req0_i & ~blocked0;
  assign elig1     = Req1_i & ~blocked1;
  assign owner_req = grant0 ? Req0_i : Req1_i;

  always_ff @(posedge Clk_i or negedge Reset_n_i) begin
    if (!Reset_n_i) begin
      state       <= IDLE;
      last_served <= 1'b1;
      blocked0    <= 1'b0;
      blocked1    <= 1'b0;
      grant0      <= 1'b0;
      grant1      <= 1'b0;
      timeout_irq <= 1'b0;
      hold_cnt    <= '0;
    end else begin
      timeout_irq <= 1'b0;
      if (!Req0_i) blocked0 <= 1'b0;
      if (!Req1_i) blocked1 <= 1'b0;
      case (state)
        IDLE: begin
          // On a tie, last_served=1 means requester 0 is due
          if (elig0 && (!elig1 || last_served)) begin
            state       <= GRANT0;
            grant0      <= 1'b1;
            last_served <= 1'b0;
            hold_cnt    <= Timeout_i;
          end else if (elig1) begin
            state       <= GRANT1;
            grant1      <= 1'b1;
            last_served <= 1'b1;
            hold_cnt    <= Timeout_i;
          end
        end
        GRANT0, GRANT1: begin
          if (!owner_req) begin
            state  <= DRAIN;
            grant0 <= 1'b0;
            grant1 <= 1'b0;
          end else if (hold_cnt == TimeoutWidth'(1)) begin
            state       <= DRAIN;
            grant0      <= 1'b0;
            grant1      <= 1'b0;
            timeout_irq <= 1'b1;
            if (grant0) blocked0 <= 1'b1;
            else        blocked1 <= 1'b1;
          end else if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - TimeoutWidth'(1);
          end
        end
        DRAIN: begin
          if (!SPI_Transmission_i && SPI_FIFOEmpty_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    SPI_Write_o    = 1'b0;
    SPI_ReadNext_o = 1'b0;
    SPI_Data_o     = '0;
    if (grant0) begin
      SPI_Write_o    = Req0_SPI_Write_i;
      SPI_ReadNext_o = Req0_SPI_ReadNext_i;
      SPI_Data_o     = Req0_SPI_Data_i;
    end else if (grant1) begin
      SPI_Write_o    = Req1_SPI_Write_i;
      SPI_ReadNext_o = Req1_SPI_ReadNext_i;
      SPI_Data_o     = Req1_SPI_Data_i;
    end
  end

  // A requester without the bus sees a full, empty, busy master so it never starts anything
  assign Req0_SPI_FIFOFull_o     = grant0 ? SPI_FIFOFull_i     : 1'b1;
  assign Req0_SPI_FIFOEmpty_o    = grant0 ? SPI_FIFOEmpty_i    : 1'b1;
  assign Req0_SPI_Transmission_o = grant0 ? SPI_Transmission_i : 1'b1;
  assign Req1_SPI_FIFOFull_o     = grant1 ? SPI_FIFOFull_i     : 1'b1;
  assign Req1_SPI_FIFOEmpty_o    = grant1 ? SPI_FIFOEmpty_i    : 1'b1;
  assign Req1_SPI_Transmission_o = grant1 ? SPI_Transmission_i : 1'b1;

  assign CS0_n_o      = grant0 ? Req0_CS_n_i : 1'b1;
  assign CS1_n_o      = grant1 ? Req1_CS_n_i : 1'b1;
  assign Grant0_o     = grant0;
  assign Grant1_o     = grant1;
  assign TimeoutIrq_o = timeout_irq;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_arbiter.sv
`default_nettype none
// tb_spi_master_arbiter: vector table, directed corner sequences and random traffic
// checked against a cycle-level reference model of the arbiter.
module tb_spi_master_arbiter;
  localparam int DW = 8;
  localparam int TW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          req0, req1, w0, w1, rn0, rn1, cs0, cs1;
  logic [DW-1:0] d0, d1;
  logic          full, empty, trans;
  logic [TW-1:0] tmo;

  logic          grant0, grant1, irq, spi_wr, spi_rn, cs0_o, cs1_o;
  logic [DW-1:0] spi_data;
  logic          f0o, e0o, t0o, f1o, e1o, t1o;

  spi_master_arbiter #(.DataWidth(DW), .TimeoutWidth(TW)) dut (
    .Clk_i(clk), .Reset_n_i(rst_n),
    .Req0_i(req0), .Req1_i(req1),
    .Grant0_o(grant0), .Grant1_o(grant1),
    .Req0_SPI_Write_i(w0), .Req0_SPI_ReadNext_i(rn0), .Req0_SPI_Data_i(d0), .Req0_CS_n_i(cs0),
    .Req1_SPI_Write_i(w1), .Req1_SPI_ReadNext_i(rn1), .Req1_SPI_Data_i(d1), .Req1_CS_n_i(cs1),
    .Req0_SPI_FIFOFull_o(f0o), .Req0_SPI_FIFOEmpty_o(e0o), .Req0_SPI_Transmission_o(t0o),
    .Req1_SPI_FIFOFull_o(f1o), .Req1_SPI_FIFOEmpty_o(e1o), .Req1_SPI_Transmission_o(t1o),
    .SPI_Data_o(spi_data), .SPI_Write_o(spi_wr), .SPI_ReadNext_o(spi_rn),
    .SPI_FIFOFull_i(full), .SPI_FIFOEmpty_i(empty), .SPI_Transmission_i(trans),
    .CS0_n_o(cs0_o), .CS1_n_o(cs1_o),
    .Timeout_i(tmo), .TimeoutIrq_o(irq)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: owner -1 = nobody, 0/1 = bus holder, 2 = draining
  int owner;
  int left;
  int last;
  bit blk [2];
  bit m_irq;

  task automatic model_reset();
    owner  = -1;
    left   = 0;
    last   = 1;
    blk[0] = 1'b0;
    blk[1] = 1'b0;
    m_irq  = 1'b0;
  endtask

  task automatic model_step();
    int o;
    bit e0, e1, r, nirq;
    o    = owner;
    nirq = 1'b0;
    if (o == -1) begin
      e0 = req0 && !blk[0];
      e1 = req1 && !blk[1];
      if (e0 && e1)  owner = 1 - last;
      else if (e0)   owner = 0;
      else if (e1)   owner = 1;
      if (owner != -1) begin
        last = owner;
        left = int'(tmo);
      end
    end else if (o == 2) begin
      if (!trans && empty) owner = -1;
    end else begin
      r = (o == 0) ? req0 : req1;
      if (!r) owner = 2;
      else if (left == 1) begin
        owner  = 2;
        nirq   = 1'b1;
        blk[o] = 1'b1;
      end else if (left > 1) left = left - 1;
    end
    if (!req0) blk[0] = 1'b0;
    if (!req1) blk[1] = 1'b0;
    m_irq = nirq;
  endtask

  function automatic logic [20:0] act_vec();
    return {grant0, grant1, irq, spi_wr, spi_rn, spi_data, cs0_o, cs1_o,
            f0o, e0o, t0o, f1o, e1o, t1o};
  endfunction

  function automatic logic [20:0] exp_vec();
    logic g0, g1, wr, rn;
    logic [DW-1:0] dt;
    g0 = (owner == 0);
    g1 = (owner == 1);
    wr = g0 ? w0 : (g1 ? w1 : 1'b0);
    rn = g0 ? rn0 : (g1 ? rn1 : 1'b0);
    dt = g0 ? d0 : (g1 ? d1 : '0);
    return {g0, g1, m_irq, wr, rn, dt, g0 ? cs0 : 1'b1, g1 ? cs1 : 1'b1,
            g0 ? full : 1'b1, g0 ? empty : 1'b1, g0 ? trans : 1'b1,
            g1 ? full : 1'b1, g1 ? empty : 1'b1, g1 ? trans : 1'b1};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input bit chk);
    @(posedge clk);
    model_step();
    #1;
    if (chk) check("cycle", 32'(act_vec()), 32'(exp_vec()));
  endtask

  task automatic go_idle();
    req0 = 0; req1 = 0; w0 = 0; w1 = 0; rn0 = 0; rn1 = 0;
    cs0 = 1; cs1 = 1; full = 0; empty = 1; trans = 0;
    repeat (3) tick(1);
  endtask

  typedef struct {
    int            who;
    logic          w0, w1;
    logic [DW-1:0] d0, d1;
    logic          cs0, cs1, full, trans;
    logic          wr;
    logic [DW-1:0] data;
    logic          cs0o, cs1o, f0, f1, t0, t1;
  } vec_t;

  vec_t tbl [5];
  int   n_g, n_irq, lost;

  initial begin
    tbl[0] = '{0, 1, 0, 8'hA5, 8'h3C, 0, 0, 0, 0,  1, 8'hA5, 0, 1, 0, 1, 0, 1};
    tbl[1] = '{1, 1, 0, 8'hA5, 8'h3C, 0, 0, 1, 0,  0, 8'h3C, 1, 0, 1, 1, 1, 0};
    tbl[2] = '{1, 0, 1, 8'h11, 8'hF0, 1, 1, 0, 1,  1, 8'hF0, 1, 1, 1, 0, 1, 1};
    tbl[3] = '{2, 1, 1, 8'hFF, 8'hFF, 0, 0, 0, 0,  0, 8'h00, 1, 1, 1, 1, 1, 1};
    tbl[4] = '{0, 0, 1, 8'h00, 8'h77, 1, 0, 1, 1,  0, 8'h00, 1, 1, 1, 1, 1, 1};

    // Reset with busy-looking inputs: outputs must still be quiet
    rst_n = 0; req0 = 1; req1 = 1; w0 = 1; w1 = 1; rn0 = 1; rn1 = 1;
    cs0 = 0; cs1 = 0; d0 = 8'h5A; d1 = 8'hC3; full = 0; empty = 0; trans = 0; tmo = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 32'(act_vec()), 32'(exp_vec()));
    req0 = 0; req1 = 0;
    rst_n = 1;
    go_idle();

    // Simultaneous requests: 0 wins the first tie, 1 gets the bus after drain
    req0 = 1; req1 = 1; cs0 = 0;
    tick(1);
    check("tie_grant0", {30'd0, grant0, grant1}, 32'b10);
    repeat (2) tick(1);
    trans = 1; empty = 0; req0 = 0;
    tick(1);
    check("drain_no_grant_a", {30'd0, grant0, grant1}, 32'b00);
    tick(1);
    check("drain_no_grant_b", {30'd0, grant0, grant1}, 32'b00);
    trans = 0; empty = 1;
    tick(1);
    check("drain_to_idle", {30'd0, grant0, grant1}, 32'b00);
    tick(1);
    check("handover_grant1", {31'd0, grant1}, 32'd1);
    go_idle();

    // Idle requester strobes must not leak onto the bus
    req0 = 1;
    tick(1);
    full = 0; w1 = 1;
    #1;
    check("idle_req1_write_blocked", {31'd0, spi_wr}, 32'd0);
    check("idle_req1_sees_full", {31'd0, f1o}, 32'd1);
    w1 = 0;
    go_idle();

    for (int i = 0; i < 5; i++) begin
      go_idle();
      if (tbl[i].who == 0) req0 = 1;
      if (tbl[i].who == 1) req1 = 1;
      tick(1);
      w0 = tbl[i].w0; w1 = tbl[i].w1; d0 = tbl[i].d0; d1 = tbl[i].d1;
      cs0 = tbl[i].cs0; cs1 = tbl[i].cs1; full = tbl[i].full; trans = tbl[i].trans;
      #1;
      check($sformatf("table_%0d", i),
            {19'd0, spi_wr, spi_data, cs0_o, cs1_o, f0o, f1o, t0o, t1o},
            {19'd0, tbl[i].wr, tbl[i].data, tbl[i].cs0o, tbl[i].cs1o,
             tbl[i].f0, tbl[i].f1, tbl[i].t0, tbl[i].t1});
    end

    // Forced revoke after 5 grant cycles, then blocked until the request toggles
    go_idle();
    tmo = TW'(5); req0 = 1; cs0 = 0;
    n_g = 0; n_irq = 0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (grant0) n_g++;
      if (irq) begin
        n_irq++;
        check("t5_cs0_high_at_irq", {31'd0, cs0_o}, 32'd1);
      end
    end
    check("t5_grant_cycles", n_g, 5);
    check("t5_irq_pulses", n_irq, 1);
    check("t5_still_blocked", {31'd0, grant0}, 32'd0);
    req0 = 0;
    tick(1);
    req0 = 1;
    tick(1);
    check("t5_regrant_after_toggle", {31'd0, grant0}, 32'd1);

    // Release in the same cycle the counter would expire
    go_idle();
    tmo = TW'(3); req0 = 1;
    repeat (3) tick(1);
    req0 = 0;
    tick(1);
    check("exp_release_no_irq", {31'd0, irq}, 32'd0);
    check("exp_release_dropped", {31'd0, grant0}, 32'd0);
    tick(1);
    check("exp_release_no_irq_late", {31'd0, irq}, 32'd0);
    req0 = 1;
    tick(1);
    check("exp_release_regrant", {31'd0, grant0}, 32'd1);

    // Random traffic against the model
    go_idle();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(7) == 0) req0 = ~req0;
      if ($urandom_range(7) == 0) req1 = ~req1;
      w0 = 1'($urandom_range(1)); w1 = 1'($urandom_range(1));
      rn0 = 1'($urandom_range(1)); rn1 = 1'($urandom_range(1));
      cs0 = 1'($urandom_range(1)); cs1 = 1'($urandom_range(1));
      d0 = DW'($urandom); d1 = DW'($urandom);
      full = 1'($urandom_range(1));
      empty = ($urandom_range(3) != 0);
      trans = ($urandom_range(2) == 0);
      if ($urandom_range(15) == 0) tmo = TW'($urandom_range(6));
      tick(1);
    end

    // Reset mid-grant: chip select must rise without waiting for a clock
    go_idle();
    tmo = '0; req1 = 1; cs1 = 0;
    tick(1);
    check("pre_reset_cs1_low", {31'd0, cs1_o}, 32'd0);
    #2;
    rst_n = 0;
    model_reset();
    #1;
    check("async_reset_cs1", {31'd0, cs1_o}, 32'd1);
    check("async_reset_outputs", 32'(act_vec()), 32'(exp_vec()));
    @(posedge clk);
    #1;
    check("held_reset_outputs", 32'(act_vec()), 32'(exp_vec()));
    req1 = 0;
    rst_n = 1;
    go_idle();

    // Timeout disabled: long hold never expires
    tmo = '0; req1 = 1;
    tick(1);
    n_irq = 0; lost = 0;
    for (int c = 0; c < 70000; c++) begin
      tick(0);
      if (irq) n_irq++;
      if (!grant1) lost++;
    end
    check("t0_irq_count", n_irq, 0);
    check("t0_grant_drops", lost, 0);
    go_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
